gate_pair_packer: RTL

- Downstream consumer of the NAND/XOR gate stage. Samples its two result bits (f1, f2) on each valid cycle and packs PAIRS consecutive pairs into one word.
- Buffers completed words in a DEPTH-entry FIFO and presents them on a valid/ready output port, so gate results can be logged or checked downstream.

---
 rtl/gate_pair_if.sv | 20 ++
 rtl/gate_pair_packer.sv | 60 ++++++
 2 files changed

// File: rtl/gate_pair_if.sv
// gate_pair_if: pair input, flush and packed-word output handshake bundle for gate_pair_packer
interface gate_pair_if #(parameter int PAIRS = 4, parameter int DEPTH = 4);
  logic in_valid, in_ready, f1, f2, flush;
  logic out_valid, out_ready;
  logic [2*PAIRS-1:0] out_data;
  logic [4:0] out_pairs;
  logic [$clog2(DEPTH):0] fifo_count;
`ifdef GATE_PAIR_PACKER_ONES_CNT_EN
  logic [15:0] ones_count;
  modport master (output in_valid, f1, f2, flush, out_ready,
                  input in_ready, out_valid, out_data, out_pairs, fifo_count, ones_count);
  modport slave (input in_valid, f1, f2, flush, out_ready,
                 output in_ready, out_valid, out_data, out_pairs, fifo_count, ones_count);
`else
  modport master (output in_valid, f1, f2, flush, out_ready,
                  input in_ready, out_valid, out_data, out_pairs, fifo_count);
  modport slave (input in_valid, f1, f2, flush, out_ready,
                 output in_ready, out_valid, out_data, out_pairs, fifo_count);
`endif
endinterface

// File: rtl/gate_pair_packer.sv
// gate_pair_packer: packs f1/f2 pairs into words queued in a FIFO; GATE_PAIR_PACKER_ONES_CNT_EN adds ones_count
module gate_pair_packer #(
  parameter int PAIRS = 4,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  gate_pair_if.slave bus
);
  localparam int W = 2 * PAIRS;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0] pair_cnt, held;
  logic [W-1:0] shift, word;
  logic [W-1:0] mem_data [DEPTH];
  logic [4:0] mem_pairs [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic full, acc, push, pop;
  assign full = count == CW'(DEPTH);
  assign bus.in_ready = !(full && pair_cnt == 5'(PAIRS - 1));
  assign acc = bus.in_valid && bus.in_ready;
  assign held = pair_cnt + 5'(acc);
  assign word = shift | (acc ? W'({bus.f2, bus.f1}) << (2 * pair_cnt) : '0);
  // a flush may push only when there is room, so a full FIFO keeps the partial word
  assign push = (acc && pair_cnt == 5'(PAIRS - 1)) || (bus.flush && !full && held != 0);
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.out_valid = count != 0;
  assign bus.out_data = bus.out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_pairs = bus.out_valid ? mem_pairs[rd_ptr] : '0;
  assign bus.fifo_count = count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pair_cnt <= '0;
      shift <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      pair_cnt <= push ? '0 : held;
      shift <= push ? '0 : word;
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_data[wr_ptr] <= word;
      mem_pairs[wr_ptr] <= held;
    end
`ifdef GATE_PAIR_PACKER_ONES_CNT_EN
  logic [15:0] ones;
  logic [16:0] ones_sum;
  assign ones_sum = 17'(ones) + 17'(bus.f1) + 17'(bus.f2);
  assign bus.ones_count = ones;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ones <= '0;
    else if (acc) ones <= ones_sum[16] ? 16'hFFFF : ones_sum[15:0];
`endif
endmodule
